// File: rtl/traffic_light_pkg.sv
// Shared definitions for the timed two-road traffic light controller:
// lamp colour codes, FSM state encodings and the phase-elapsed test.
package traffic_light_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] OFF    = 2'd3;

  typedef enum logic [2:0] {
    ST_HG    = 3'd0,
    ST_HY    = 3'd1,
    ST_AR1   = 3'd2,
    ST_SG    = 3'd3,
    ST_SY    = 3'd4,
    ST_AR2   = 3'd5,
    ST_FLASH = 3'd6
  } state_e;

  // A phase of duration dur has elapsed once the counter reaches dur-1,
  // so a fixed phase lasts exactly dur cycles.
  function automatic logic elapsed(input int unsigned cnt, input int unsigned dur);
    return (cnt + 1) >= dur;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_timed_tl_phase_timer.sv
// Saturating up-counter with synchronous clear; used both as the phase
// timer and as the flash blink divider.
module tl_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/traffic_light_ctrl_timed.sv
// Highway / small-road light controller with counter-timed phases, all-red
// clearance, min/max side green, latched pedestrian request and night flash.
module traffic_light_ctrl_timed
  import traffic_light_pkg::*;
#(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned MIN_GREEN_MAIN = 10,
  parameter int unsigned YELLOW_TIME    = 3,
  parameter int unsigned ALL_RED_TIME   = 2,
  parameter int unsigned MIN_GREEN_SIDE = 4,
  parameter int unsigned MAX_GREEN_SIDE = 8,
  parameter int unsigned FLASH_HALF     = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       sensor,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic [1:0] highway,
  output logic [1:0] small_road,
  output logic       walk
);

  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

  state_e           state_q, state_d;
  logic             ped_lat_q, ped_lat_d;
  logic             blink_q, blink_d;
  logic [1:0]       highway_q, small_road_q;
  logic             walk_q;

  logic [1:0]       tmr_clr;
  logic [1:0]       tmr_en;
  logic [CNT_W-1:0] tmr_cnt [2];
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] blink_cnt;
  logic             flash_entry;
  logic             blink_wrap;

  // Timer 0 is the phase counter, timer 1 the blink divider.
  for (genvar gi = 0; gi < 2; gi++) begin : g_tmr
    tl_phase_timer #(.CNT_W(CNT_W)) u_tmr (
      .clk   (clk),
      .clr_i (tmr_clr[gi]),
      .en_i  (tmr_en[gi]),
      .cnt_o (tmr_cnt[gi])
    );
  end

  assign phase_cnt = tmr_cnt[0];
  assign blink_cnt = tmr_cnt[1];

  function automatic logic [4:0] lamps(input state_e s, input logic b);
    case (s)
      ST_HG:    return {GREEN, RED, 1'b0};
      ST_HY:    return {YELLOW, RED, 1'b0};
      ST_SG:    return {RED, GREEN, 1'b1};
      ST_SY:    return {RED, YELLOW, 1'b0};
      ST_FLASH: return b ? {YELLOW, RED, 1'b0} : {OFF, OFF, 1'b0};
      default:  return {RED, RED, 1'b0};
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HG: begin
        if (flash_mode) begin
          state_d = ST_FLASH;
        end else if (elapsed(32'(phase_cnt), MIN_GREEN_MAIN) && (sensor || ped_lat_q)) begin
          state_d = ST_HY;
        end
      end
      ST_HY:  if (elapsed(32'(phase_cnt), YELLOW_TIME))  state_d = ST_AR1;
      ST_AR1: if (elapsed(32'(phase_cnt), ALL_RED_TIME)) state_d = ST_SG;
      ST_SG: begin
        if (elapsed(32'(phase_cnt), MAX_GREEN_SIDE) ||
            (elapsed(32'(phase_cnt), MIN_GREEN_SIDE) && !sensor)) begin
          state_d = ST_SY;
        end
      end
      ST_SY:    if (elapsed(32'(phase_cnt), YELLOW_TIME))  state_d = ST_AR2;
      ST_AR2:   if (elapsed(32'(phase_cnt), ALL_RED_TIME)) state_d = ST_HG;
      ST_FLASH: if (!flash_mode) state_d = ST_AR2;
      default:  state_d = ST_HG;
    endcase

    flash_entry = (state_d == ST_FLASH) && (state_q != ST_FLASH);
    blink_wrap  = (state_q == ST_FLASH) && (blink_cnt == FLASH_LAST);

    blink_d = blink_q;
    if (flash_entry) begin
      blink_d = 1'b1;
    end else if (blink_wrap) begin
      blink_d = ~blink_q;
    end

    // Entering SG consumes the request, even one arriving on the same edge.
    ped_lat_d = ped_lat_q;
    if ((state_d == ST_SG) && (state_q != ST_SG)) begin
      ped_lat_d = 1'b0;
    end else if (ped_req && (state_q != ST_SG)) begin
      ped_lat_d = 1'b1;
    end

    tmr_clr[0] = clr || (state_d != state_q);
    tmr_en[0]  = 1'b1;
    tmr_clr[1] = clr || flash_entry || blink_wrap;
    tmr_en[1]  = (state_q == ST_FLASH);
  end

  // Lamps are registered from the next state so they track the state
  // register without any added latency.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= ST_HG;
      ped_lat_q    <= 1'b0;
      blink_q      <= 1'b1;
      highway_q    <= GREEN;
      small_road_q <= RED;
      walk_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      ped_lat_q <= ped_lat_d;
      blink_q   <= blink_d;
      {highway_q, small_road_q, walk_q} <= lamps(state_d, blink_d);
    end
  end

  assign highway    = highway_q;
  assign small_road = small_road_q;
  assign walk       = walk_q;

endmodule
